exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  stage clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low; asserted when 0.
REQ-004 EXE_CMD  in  4  ALU command from ID (0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR).
REQ-005 WB_EN, MEM_R_EN, MEM_W_EN, S, B  in  1 each  control bits from ID.
REQ-006 PC  in  32  PC value forwarded by ID.
REQ-007 Val_Rn, Val_Rm  in  32 each  register-file operands.
REQ-008 imm  in  1 / Shift_Operand  in  12 / Signed_imm_24  in  24 / Dest  in  4  instruction fields from ID.
REQ-009 sel_src1, sel_src2  in  2 each  forwarding select: 00 register value, 01 MEM_fwd, 10 WB_fwd, 11 register value.
REQ-010 MEM_fwd, WB_fwd  in  32 each  forwarded results from MEM and WB stages.
REQ-011 freeze  in  1  hold all state this cycle.
REQ-012 ALU_Res_out  out  32 / Val_Rm_out  out  32 / Dest_out  out  4 / WB_EN_out, MEM_R_EN_out, MEM_W_EN_out  out  1 each  registered EXE/MEM outputs.
REQ-013 Status_out  out  32  {N,Z,C,V} in bits 31:28; bits 27:0 SHALL read 0.
REQ-014 Branch_taken  out  1 / Branch_Addr  out  32  combinational branch outputs.

Function
REQ-015 op1 SHALL be the sel_src1-selected Val_Rn. Store data SHALL be the sel_src2-selected Val_Rm.
REQ-016 Val2 with imm=1 SHALL be Shift_Operand[7:0] zero-extended, then rotated right by 2*Shift_Operand[11:8].
REQ-017 Val2 with imm=0 and (MEM_R_EN or MEM_W_EN) SHALL be Shift_Operand zero-extended to 32 bits.
REQ-018 Val2 otherwise SHALL be the forwarded Rm shifted by Shift_Operand[11:7]. Shift type from [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Bit 4 is ignored.
REQ-019 ALU results: MOV = Val2; MVN = ~Val2; ADD = op1+Val2; ADC = op1+Val2+C; SUB = op1-Val2; SBC = op1-Val2-~C; AND/ORR/EOR bitwise. Unlisted codes SHALL give result 0.
REQ-020 Flags: N = res[31]; Z = (res==0).
REQ-021 C SHALL be carry-out of the 33-bit add for ADD/ADC, and NOT borrow for SUB/SBC; logical ops and MOV/MVN SHALL keep C.
REQ-022 V SHALL be signed overflow for ADD/ADC/SUB/SBC; other ops SHALL keep V.
REQ-023 Status register SHALL load {N,Z,C,V} on the rising edge when S=1 and freeze=0; otherwise it SHALL hold.
REQ-024 The EXE/MEM register SHALL capture ALU result, store data, Dest and the three enables each edge with freeze=0; latency is 1 cycle.
REQ-025 With freeze=1 the EXE/MEM register and status register SHALL hold, including a freeze coinciding with S=1.
REQ-026 Branch_taken SHALL equal B. Branch_Addr SHALL be PC + (sign-extended Signed_imm_24 shifted left 2), mod 2^32.
REQ-027 Arithmetic wraps mod 2^32. Shift/rotate amount 0 SHALL return the operand unchanged.

Reset
REQ-028 rst=0 SHALL immediately clear all registered outputs and Status_out to 0, regardless of clk or freeze.
REQ-029 Deassertion mid-pipeline SHALL resume capture from the next rising edge. No in-flight value survives reset.

Structure
REQ-030 EXE_CMD encodings and shift-type codes SHALL live in a shared package used by ID and EXE.
REQ-031 The ALU (op1, Val2, EXE_CMD, C_in -> result, N, Z, C, V) SHALL be a sub-module named alu. The Val2 generator stays inline.

Verification
REQ-032 Reset: rst=0 mid-run -> all registered outputs and Status_out = 0 without a clock edge.
REQ-033 ADD overflow: Val_Rn=0x7FFFFFFF, imm=1, Shift_Operand=0x001, S=1 -> next edge ALU_Res_out=0x80000000 and Status_out[31:28]=1001.
REQ-034 SUB equal: op1=5, imm=1, Shift_Operand=0x005, EXE_CMD=0100, S=1 -> ALU_Res_out=0 and Status_out[31:28]=0110.
REQ-035 Rotate immediate: MOV, imm=1, Shift_Operand=0x4FF -> ALU_Res_out=0xFF000000.
REQ-036 Forwarding plus shift: ADD, sel_src1=01, MEM_fwd=0x10, sel_src2=00, Val_Rm=3, Shift_Operand=0x103 -> ALU_Res_out=0x1C.
REQ-037 Branch and freeze: B=1, PC=0x100, Signed_imm_24=0xFFFFFE -> Branch_taken=1, Branch_Addr=0xF8. Then freeze=1 with new ADD, S=1 -> outputs and Status_out unchanged.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - ALU command and shift-type encodings shared by ID and EXE.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  // Doubling the word makes a zero rotate amount fall out naturally.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - 32-bit ALU producing result and NZCV flags.
module alu
  import exe_stage_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] val2,
  input  logic [3:0]  exe_cmd,
  input  logic        c_in,
  input  logic        v_in,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic [32:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = c_in;
    v      = v_in;
    case (exe_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, op1} + {1'b0, val2} + {32'd0, (exe_cmd == CMD_ADC) & c_in};
        result = sum[31:0];
        c      = sum[32];
        v      = (op1[31] == val2[31]) && (result[31] != op1[31]);
      end
      // Subtract as op1 + ~val2 + carry so the carry-out is NOT borrow.
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, op1} + {1'b0, ~val2} + {32'd0, (exe_cmd == CMD_SUB) | c_in};
        result = sum[31:0];
        c      = sum[32];
        v      = (op1[31] != val2[31]) && (result[31] != op1[31]);
      end
      CMD_AND: result = op1 & val2;
      CMD_ORR: result = op1 | val2;
      CMD_EOR: result = op1 ^ val2;
      default: result = '0;
    endcase
  end

  assign n = result[31];
  assign z = (result == 32'd0);

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - Execute stage: forwarding, operand-2 generation, ALU,
// status register, EXE/MEM pipeline register and branch target.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic        B,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        imm,
  input  logic [11:0] Shift_Operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] MEM_fwd,
  input  logic [31:0] WB_fwd,
  input  logic        freeze,
  output logic [31:0] ALU_Res_out,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic [31:0] Status_out,
  output logic        Branch_taken,
  output logic [31:0] Branch_Addr
);

  logic [31:0] op1;
  logic [31:0] rm_fwd;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [3:0]  status_q;
  logic [4:0]  amt;

  always_comb begin
    op1 = Val_Rn;
    case (sel_src1)
      2'b01:   op1 = MEM_fwd;
      2'b10:   op1 = WB_fwd;
      default: op1 = Val_Rn;
    endcase
    rm_fwd = Val_Rm;
    case (sel_src2)
      2'b01:   rm_fwd = MEM_fwd;
      2'b10:   rm_fwd = WB_fwd;
      default: rm_fwd = Val_Rm;
    endcase
  end

  assign amt = Shift_Operand[11:7];

  always_comb begin
    val2 = '0;
    if (imm)
      val2 = ror32({24'd0, Shift_Operand[7:0]}, {Shift_Operand[11:8], 1'b0});
    else if (MEM_R_EN || MEM_W_EN)
      val2 = {20'd0, Shift_Operand};
    else begin
      case (Shift_Operand[6:5])
        SH_LSL:  val2 = rm_fwd << amt;
        SH_LSR:  val2 = rm_fwd >> amt;
        SH_ASR:  val2 = 32'($signed(rm_fwd) >>> amt);
        default: val2 = ror32(rm_fwd, amt);
      endcase
    end
  end

  alu u_alu (
    .op1     (op1),
    .val2    (val2),
    .exe_cmd (EXE_CMD),
    .c_in    (status_q[1]),
    .v_in    (status_q[0]),
    .result  (alu_res),
    .n       (alu_n),
    .z       (alu_z),
    .c       (alu_c),
    .v       (alu_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALU_Res_out  <= '0;
      Val_Rm_out   <= '0;
      Dest_out     <= '0;
      WB_EN_out    <= 1'b0;
      MEM_R_EN_out <= 1'b0;
      MEM_W_EN_out <= 1'b0;
      status_q     <= '0;
    end else if (!freeze) begin
      ALU_Res_out  <= alu_res;
      Val_Rm_out   <= rm_fwd;
      Dest_out     <= Dest;
      WB_EN_out    <= WB_EN;
      MEM_R_EN_out <= MEM_R_EN;
      MEM_W_EN_out <= MEM_W_EN;
      if (S)
        status_q <= {alu_n, alu_z, alu_c, alu_v};
    end
  end

  assign Status_out   = {status_q, 28'd0};
  assign Branch_taken = B;
  assign Branch_Addr  = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - Directed and randomized bench for exe_stage against an
// arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, S, B;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_Operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] MEM_fwd, WB_fwd;
  logic        freeze;
  logic [31:0] ALU_Res_out, Val_Rm_out;
  logic [3:0]  Dest_out;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
  logic [31:0] Status_out;
  logic        Branch_taken;
  logic [31:0] Branch_Addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res, exp_rm;
  logic [3:0]  exp_dest, exp_flags;
  logic        exp_wb, exp_mr, exp_mw;

  localparam longint unsigned MASK = 64'hFFFF_FFFF;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  exe_stage dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .S(S), .B(B), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
    .imm(imm), .Shift_Operand(Shift_Operand), .Signed_imm_24(Signed_imm_24),
    .Dest(Dest), .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_fwd(MEM_fwd),
    .WB_fwd(WB_fwd), .freeze(freeze), .ALU_Res_out(ALU_Res_out),
    .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out), .WB_EN_out(WB_EN_out),
    .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .Status_out(Status_out), .Branch_taken(Branch_taken), .Branch_Addr(Branch_Addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic longint unsigned rotr(input longint unsigned x, input int n);
    if (n == 0) return x;
    return ((x >> n) | (x << (32 - n))) & MASK;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'b01) return MEM_fwd;
    if (sel == 2'b10) return WB_fwd;
    return reg_v;
  endfunction

  function automatic logic [31:0] mdl_baddr();
    longint off, pcl, r;
    off = longint'(Signed_imm_24);
    if (off >= 8388608) off = off - 16777216;
    pcl = longint'(PC);
    r = (pcl + off * 4) & 64'sh0_FFFF_FFFF;
    return r[31:0];
  endfunction

  task automatic predict();
    longint unsigned a, b, xr, r;
    longint sa, sb, sr, ci;
    logic [31:0] rm;
    int amt;
    logic c, v;
    c  = exp_flags[1];
    v  = exp_flags[0];
    ci = exp_flags[1] ? 1 : 0;
    a  = pick(sel_src1, Val_Rn);
    rm = pick(sel_src2, Val_Rm);
    xr = rm;
    if (imm)
      b = rotr(Shift_Operand[7:0], 2 * Shift_Operand[11:8]);
    else if (MEM_R_EN || MEM_W_EN)
      b = Shift_Operand;
    else begin
      amt = Shift_Operand[11:7];
      case (Shift_Operand[6:5])
        2'd0: b = (xr * (64'd1 << amt)) & MASK;
        2'd1: b = xr / (64'd1 << amt);
        2'd2: begin sr = $signed(rm); b = (sr >>> amt) & MASK; end
        default: b = rotr(xr, amt);
      endcase
    end
    sa = $signed(a[31:0]);
    sb = $signed(b[31:0]);
    sr = 0;
    case (EXE_CMD)
      4'b0001: r = b;
      4'b1001: r = ~b & MASK;
      4'b0010, 4'b0011: begin
        if (EXE_CMD == 4'b0010) ci = 0;
        r = a + b + ci;
        c = (r > MASK);
        sr = sa + sb + ci;
        v = (sr > MAXV) || (sr < MINV);
      end
      4'b0100, 4'b0101: begin
        ci = (EXE_CMD == 4'b0100) ? 0 : 1 - ci;
        r = (a - b - ci) & MASK;
        c = (a >= b + ci);
        sr = sa - sb - ci;
        v = (sr > MAXV) || (sr < MINV);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: r = 0;
    endcase
    r = r & MASK;
    if (!freeze) begin
      exp_res  = r[31:0];
      exp_rm   = rm;
      exp_dest = Dest;
      exp_wb   = WB_EN;
      exp_mr   = MEM_R_EN;
      exp_mw   = MEM_W_EN;
      if (S) exp_flags = {r[31], r == 0, c, v};
    end
  endtask

  task automatic mdl_reset();
    exp_res = 0; exp_rm = 0; exp_dest = 0; exp_flags = 0;
    exp_wb = 0; exp_mr = 0; exp_mw = 0;
  endtask

  task automatic check_all();
    chk("alu_res", ALU_Res_out, exp_res);
    chk("val_rm", Val_Rm_out, exp_rm);
    chk("dest", {28'd0, Dest_out}, {28'd0, exp_dest});
    chk("enables", {29'd0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}, {29'd0, exp_wb, exp_mr, exp_mw});
    chk("status", Status_out, {exp_flags, 28'd0});
    chk("br_taken", {31'd0, Branch_taken}, {31'd0, B});
    chk("br_addr", Branch_Addr, mdl_baddr());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res"}, ALU_Res_out, 32'd0);
    chk({tag, "_rm"}, Val_Rm_out, 32'd0);
    chk({tag, "_ctl"}, {24'd0, Dest_out, 1'b0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}, 32'd0);
    chk({tag, "_status"}, Status_out, 32'd0);
  endtask

  task automatic clear_inputs();
    EXE_CMD = 0; WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; S = 0; B = 0;
    PC = 0; Val_Rn = 0; Val_Rm = 0; imm = 0; Shift_Operand = 0;
    Signed_imm_24 = 0; Dest = 0; sel_src1 = 0; sel_src2 = 0;
    MEM_fwd = 0; WB_fwd = 0; freeze = 0;
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    clear_inputs();
    mdl_reset();
    #1;
    check_zero("reset_init");
    @(negedge clk);
    rst = 1'b1;

    clear_inputs();
    Val_Rn = 32'h7FFF_FFFF; imm = 1; Shift_Operand = 12'h001; EXE_CMD = 4'b0010;
    S = 1; WB_EN = 1; Dest = 4'd3;
    step();
    chk("add_ovf_res", ALU_Res_out, 32'h8000_0000);
    chk("add_ovf_flags", {28'd0, Status_out[31:28]}, 32'h9);

    clear_inputs();
    Val_Rn = 32'd5; imm = 1; Shift_Operand = 12'h005; EXE_CMD = 4'b0100; S = 1;
    step();
    chk("sub_eq_res", ALU_Res_out, 32'd0);
    chk("sub_eq_flags", {28'd0, Status_out[31:28]}, 32'h6);

    clear_inputs();
    EXE_CMD = 4'b0001; imm = 1; Shift_Operand = 12'h4FF;
    step();
    chk("mov_rot_res", ALU_Res_out, 32'hFF00_0000);

    clear_inputs();
    EXE_CMD = 4'b0010; sel_src1 = 2'b01; MEM_fwd = 32'h10; Val_Rn = 32'hDEAD_BEEF;
    Val_Rm = 32'd3; Shift_Operand = 12'h103;
    step();
    chk("fwd_shift_res", ALU_Res_out, 32'h1C);

    clear_inputs();
    B = 1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
    #1;
    chk("branch_taken", {31'd0, Branch_taken}, 32'd1);
    chk("branch_addr", Branch_Addr, 32'h0000_00F8);
    step();

    clear_inputs();
    freeze = 1; EXE_CMD = 4'b0010; Val_Rn = 32'h7FFF_FFFF; imm = 1; Shift_Operand = 12'h001;
    S = 1; WB_EN = 1; Dest = 4'hF;
    step();
    chk("freeze_res", ALU_Res_out, 32'd0);
    chk("freeze_status", Status_out, 32'h6000_0000);
    chk("freeze_dest", {28'd0, Dest_out}, 32'd0);

    clear_inputs();
    EXE_CMD = 4'b0001; imm = 1; Shift_Operand = 12'h0FF; S = 1; WB_EN = 1; MEM_W_EN = 1;
    sel_src2 = 2'b10; WB_fwd = 32'hCAFE_F00D; Dest = 4'd9;
    step();
    #2;
    rst = 1'b0;
    freeze = 1;
    #1;
    mdl_reset();
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst = 1'b1;
    freeze = 0;
    step();

    for (int i = 0; i < 300; i++) begin
      EXE_CMD       = 4'($urandom_range(0, 15));
      WB_EN         = 1'($urandom);
      MEM_R_EN      = ($urandom_range(0, 3) == 0);
      MEM_W_EN      = ($urandom_range(0, 3) == 0);
      S             = 1'($urandom);
      B             = 1'($urandom);
      PC            = $urandom;
      Val_Rn        = rand_word();
      Val_Rm        = rand_word();
      imm           = 1'($urandom);
      Shift_Operand = 12'($urandom);
      Signed_imm_24 = 24'($urandom);
      Dest          = 4'($urandom);
      sel_src1      = 2'($urandom);
      sel_src2      = 2'($urandom);
      MEM_fwd       = rand_word();
      WB_fwd        = rand_word();
      freeze        = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
